// File: rtl/life_arena_engine_if.sv
// Command bus between a host and life_arena_engine.
//   cmd       : opcode (IDLE=0, SEED=1, ADVANCE=2, READ_CELL=3, 4..7 behave as IDLE)
//   cmd_arg0  : command argument, captured at the accepting clk edge
//   cmd_valid : host requests a command
//   cmd_ready : engine idle; also marks cmd_res as valid
//   cmd_res   : result of the most recently completed command
interface life_arena_engine_if;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_res;

  modport master (output cmd, cmd_arg0, cmd_valid, input cmd_ready, cmd_res);
  modport slave  (input cmd, cmd_arg0, cmd_valid, output cmd_ready, cmd_res);
endinterface

// File: rtl/life_arena_engine.sv
// Conway's Game of Life (B3/S23) engine on a toroidal ARENA_WIDTH x ARENA_HEIGHT arena.
//   clk               : command and engine clock
//   reset             : asynchronous active-low reset
//   arena_rd_clk      : clock of the read-only cell port
//   arena_rd_column/row/data_out : registered read of the current generation
//   bus               : command interface (slave side)
// Two arena buffers are kept; cur_sel names the current generation. ADVANCE
// writes one row per cycle into the other buffer and flips cur_sel in a swap
// cycle, so the read port never observes a half-built generation.
module life_arena_engine #(
  parameter int unsigned ARENA_WIDTH  = 36,
  parameter int unsigned ARENA_HEIGHT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arena_rd_clk,
  input  logic [7:0] arena_rd_column,
  input  logic [7:0] arena_rd_row,
  output logic       arena_rd_data_out,
  life_arena_engine_if.slave bus
);

  localparam int unsigned CW = (ARENA_WIDTH  > 1) ? $clog2(ARENA_WIDTH)  : 1;
  localparam int unsigned RW = (ARENA_HEIGHT > 1) ? $clog2(ARENA_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(ARENA_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ARENA_HEIGHT - 1);
  localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    OP_IDLE      = 3'd0,
    OP_SEED      = 3'd1,
    OP_ADVANCE   = 3'd2,
    OP_READ_CELL = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DONE,
    ST_SEED,
    ST_ADV,
    ST_SWAP
  } state_e;

  // Bit-sliced neighbour counter: s1:s0 is the count mod 4, s2 sticks at >=4.
  typedef struct packed {
    logic [ARENA_WIDTH-1:0] s2;
    logic [ARENA_WIDTH-1:0] s1;
    logic [ARENA_WIDTH-1:0] s0;
  } cnt_t;

  logic [ARENA_WIDTH-1:0] mem [2][ARENA_HEIGHT];
  logic                   cur_sel;
  state_e                 state, state_nxt;
  logic [31:0]            lfsr;
  logic [31:0]            gen_count;
  logic [31:0]            gens_left;
  logic [31:0]            res_pend;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;

  logic [RW-1:0]          row_up, row_dn;
  logic [ARENA_WIDTH-1:0] up, md, dn, next_row;
  cnt_t                   acc;
  logic                   cmd_cell;
  logic                   seed_last;

  // result[c] = x[c-1], wrapping column 0 to column W-1
  function automatic logic [ARENA_WIDTH-1:0] from_left(input logic [ARENA_WIDTH-1:0] x);
    return (x << 1) | (x >> (ARENA_WIDTH - 1));
  endfunction

  // result[c] = x[c+1], wrapping column W-1 to column 0
  function automatic logic [ARENA_WIDTH-1:0] from_right(input logic [ARENA_WIDTH-1:0] x);
    return (x >> 1) | (x << (ARENA_WIDTH - 1));
  endfunction

  function automatic cnt_t add_vec(input cnt_t a, input logic [ARENA_WIDTH-1:0] v);
    cnt_t                   r;
    logic [ARENA_WIDTH-1:0] c0, c1;
    c0   = a.s0 & v;
    c1   = a.s1 & c0;
    r.s0 = a.s0 ^ v;
    r.s1 = a.s1 ^ c0;
    r.s2 = a.s2 | c1;
    return r;
  endfunction

  // Next value of the row currently addressed by 'row', from the current buffer.
  always_comb begin
    row_up = (row == '0) ? ROW_LAST : row - 1'b1;
    row_dn = (row == ROW_LAST) ? '0 : row + 1'b1;
    up     = mem[cur_sel][row_up];
    md     = mem[cur_sel][row];
    dn     = mem[cur_sel][row_dn];
    acc    = '0;
    acc    = add_vec(acc, from_left(up));
    acc    = add_vec(acc, up);
    acc    = add_vec(acc, from_right(up));
    acc    = add_vec(acc, from_left(md));
    acc    = add_vec(acc, from_right(md));
    acc    = add_vec(acc, from_left(dn));
    acc    = add_vec(acc, dn);
    acc    = add_vec(acc, from_right(dn));
    // count==3, or count==2 with the cell alive
    next_row = ~acc.s2 & acc.s1 & (acc.s0 | md);
  end

  always_comb begin
    cmd_cell = 1'b0;
    if ((32'(bus.cmd_arg0[7:0]) < ARENA_WIDTH) && (32'(bus.cmd_arg0[15:8]) < ARENA_HEIGHT))
      cmd_cell = mem[cur_sel][bus.cmd_arg0[8 +: RW]][bus.cmd_arg0[0 +: CW]];
  end

  assign seed_last     = (row == ROW_LAST) && (col == COL_LAST);
  assign bus.cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            OP_SEED:    state_nxt = ST_SEED;
            OP_ADVANCE: state_nxt = (bus.cmd_arg0 == '0) ? ST_DONE : ST_ADV;
            default:    state_nxt = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_SEED: if (seed_last) state_nxt = ST_IDLE;
      ST_ADV:  if (row == ROW_LAST) state_nxt = ST_SWAP;
      ST_SWAP: state_nxt = (gens_left == 32'd1) ? ST_IDLE : ST_ADV;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem         <= '{default: '0};
      cur_sel     <= 1'b0;
      lfsr        <= 32'd1;
      gen_count   <= '0;
      gens_left   <= '0;
      res_pend    <= '0;
      row         <= '0;
      col         <= '0;
      bus.cmd_res <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            row <= '0;
            col <= '0;
            case (bus.cmd)
              OP_SEED: begin
                lfsr      <= (bus.cmd_arg0 == '0) ? 32'd1 : bus.cmd_arg0;
                gen_count <= '0;
              end
              OP_ADVANCE: begin
                gens_left <= bus.cmd_arg0;
                res_pend  <= gen_count;
              end
              OP_READ_CELL: res_pend <= {31'd0, cmd_cell};
              default:      res_pend <= '0;
            endcase
          end
        end
        ST_DONE: bus.cmd_res <= res_pend;
        ST_SEED: begin
          mem[cur_sel][row][col] <= lfsr[0];
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (seed_last) bus.cmd_res <= '0;
        end
        ST_ADV: begin
          mem[~cur_sel][row] <= next_row;
          if (row != ROW_LAST) row <= row + 1'b1;
        end
        ST_SWAP: begin
          cur_sel   <= ~cur_sel;
          gen_count <= gen_count + 32'd1;
          gens_left <= gens_left - 32'd1;
          row       <= '0;
          if (gens_left == 32'd1) bus.cmd_res <= gen_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge arena_rd_clk or negedge reset) begin
    if (!reset)
      arena_rd_data_out <= 1'b0;
    else if ((32'(arena_rd_column) < ARENA_WIDTH) && (32'(arena_rd_row) < ARENA_HEIGHT))
      arena_rd_data_out <= mem[cur_sel][arena_rd_row[RW-1:0]][arena_rd_column[CW-1:0]];
    else
      arena_rd_data_out <= 1'b0;
  end

endmodule

// File: tb/tb_life_arena_engine.sv
// Scoreboard bench for life_arena_engine: the driver pushes expected results
// computed from an array model of the arena; a monitor pops them when cmd_ready
// rises and also checks how long the engine stayed busy.
module tb_life_arena_engine;
  localparam int W = 36;
  localparam int H = 10;

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_SEED = 3'd1;
  localparam logic [2:0] C_ADV  = 3'd2;
  localparam logic [2:0] C_READ = 3'd3;

  typedef struct {
    logic [31:0] res;
    int          bmin;
    int          bmax;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rd_clk = 1'b0;
  logic       rst_n;
  logic [7:0] rd_col, rd_row;
  logic       rd_data;

  life_arena_engine_if bus();

  life_arena_engine #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .arena_rd_clk      (rd_clk),
    .arena_rd_column   (rd_col),
    .arena_rd_row      (rd_row),
    .arena_rd_data_out (rd_data),
    .bus               (bus)
  );

  always #5 clk = ~clk;
  always #7 rd_clk = ~rd_clk;

  int          tests = 0;
  int          failures = 0;
  exp_t        sbq[$];
  bit          model [H][W];
  logic [31:0] model_gen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) model[r][c] = 1'b0;
    model_gen = 0;
  endfunction

  function automatic void model_seed(input logic [31:0] arg);
    logic [31:0] s;
    s = (arg == 0) ? 32'd1 : arg;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        model[r][c] = s[0];
        s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
      end
    model_gen = 0;
  endfunction

  function automatic void model_step();
    bit nxt [H][W];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(model[(r + dr + H) % H][(c + dc + W) % W]);
        nxt[r][c] = (n == 3) || (model[r][c] && n == 2);
      end
    model = nxt;
    model_gen++;
  endfunction

  function automatic logic [31:0] model_cell(input int c, input int r);
    if (c >= W || r >= H) return 32'd0;
    return {31'd0, model[r][c]};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] arg, input logic [31:0] exp,
                       input int bmin, input int bmax, input string nm);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check({nm, "_ready_timeout"}, 32'(bus.cmd_ready), 32'd1);
      return;
    end
    e.res = exp; e.bmin = bmin; e.bmax = bmax; e.name = nm;
    sbq.push_back(e);
    bus.cmd = op;
    bus.cmd_arg0 = arg;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic read_cell(input int c, input int r, input string nm);
    logic [31:0] hi;
    logic [31:0] arg;
    hi = $urandom();
    arg = {hi[31:16], 16'd0};
    arg[7:0] = c[7:0];
    arg[15:8] = r[7:0];
    issue(C_READ, arg, model_cell(c, r), 1, 2, nm);
  endtask

  task automatic read_all(input string nm);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) read_cell(c, r, nm);
    drain();
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) model_step();
    issue(C_ADV, 32'(n), model_gen, (n == 0) ? 1 : n * (H + 1),
          (n == 0) ? 2 : n * (H + 1) + 1, "advance");
  endtask

  task automatic rd_check(input int c, input int r);
    @(negedge rd_clk);
    rd_col = c[7:0];
    rd_row = r[7:0];
    @(posedge rd_clk);
    #1 check("rd_port", 32'(rd_data), model_cell(c, r));
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_ready;
    int   busy;
    exp_t e;
    prev_ready = 1'b1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b1;
        busy = 0;
      end else begin
        if (!bus.cmd_ready) begin
          busy++;
        end else if (!prev_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check({e.name, "_res"}, bus.cmd_res, e.res);
            tests++;
            if (busy < e.bmin || busy > e.bmax) begin
              failures++;
              $display("FAIL %s_busy: got %0d cycles, expected %0d..%0d", e.name, busy, e.bmin, e.bmax);
            end
          end
          busy = 0;
        end
        prev_ready = bus.cmd_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] s;
    rst_n = 1'b0;
    bus.cmd = C_IDLE;
    bus.cmd_arg0 = '0;
    bus.cmd_valid = 1'b0;
    rd_col = '0;
    rd_row = '0;
    model_clear();
    repeat (4) @(negedge clk);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_res", bus.cmd_res, 32'd0);

    issue(C_READ, 32'h0000_0000, 32'd0, 1, 2, "read_reset_0");
    issue(C_READ, 32'h0000_0905, 32'd0, 1, 2, "read_reset_905");
    issue(C_IDLE, 32'd0, 32'd0, 1, 1, "idle");
    issue(3'd6, 32'h1234, 32'd0, 1, 1, "op6_as_idle");

    model_seed(32'hcafebabe);
    issue(C_SEED, 32'hcafebabe, 32'd0, W * H, W * H + 1, "seed_cafebabe");
    issue(C_READ, 32'h0000, 32'd0, 1, 2, "read_cafe_0");
    issue(C_READ, 32'h0001, 32'd1, 1, 2, "read_cafe_1");
    drain();
    check("model_cafe_0", model_cell(0, 0), 32'd0);
    check("model_cafe_1", model_cell(1, 0), 32'd1);

    model_seed(32'hbaadf00d);
    issue(C_SEED, 32'hbaadf00d, 32'd0, W * H, W * H + 1, "seed_baadf00d");
    read_all("read_seed");

    advance(2);
    for (int c = 2; c <= 6; c++) read_cell(c, 2, "read_gen2_row2");
    read_all("read_gen2");
    for (int i = 0; i < 6; i++) rd_check($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    rd_check(W, 0);
    rd_check(0, H);

    advance(0);
    read_all("read_adv0");
    issue(C_READ, 32'h0000_0A00, 32'd0, 1, 2, "read_row10");
    issue(C_READ, 32'h0000_0024, 32'd0, 1, 2, "read_col36");

    // cmd_valid pulsed while an ADVANCE is running must be ignored
    advance(1);
    repeat (3) @(negedge clk);
    bus.cmd = C_SEED;
    bus.cmd_arg0 = 32'h5555_aaaa;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain();
    read_all("read_after_ignored");

    for (int it = 0; it < 4; it++) begin
      s = $urandom();
      if (it == 0) s = 32'd0;
      model_seed(s);
      issue(C_SEED, s, 32'd0, W * H, W * H + 1, "seed_rand");
      advance($urandom_range(1, 3));
      for (int k = 0; k < 24; k++)
        read_cell($urandom_range(0, W + 4), $urandom_range(0, H + 2), "read_rand");
      drain();
      for (int k = 0; k < 4; k++) rd_check($urandom_range(0, W + 2), $urandom_range(0, H + 1));
    end

    // reset in the middle of a SEED
    issue(C_SEED, 32'h0f0f_1234, 32'd0, 0, 100000, "seed_aborted");
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    model_clear();
    repeat (2) @(negedge clk);
    check("midreset_ready", 32'(bus.cmd_ready), 32'd1);
    check("midreset_res", bus.cmd_res, 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    read_all("read_after_reset");
    advance(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
